// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and encodings for the multicycle RV32I controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL
  } statetype_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// rtl/multicycle_controller_aludec.sv - ALU control decode from ALUOp and instruction fields
module aludec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3_i)
          // Only R-type (op5=1) can subtract; for I-type bit 30 is an immediate bit
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM
// Optional RV_PERF_CNT_EN adds CycleCnt/InstRet performance counters.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        IllegalInstr
`ifdef RV_PERF_CNT_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstRet
`endif
);

  statetype_t state_q, state_d;
  logic [1:0] alu_op;
  logic       ir_write, pc_update, branch, mem_write, reg_write, illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (MemReady) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        case (op)
          OP_LW:   state_d = MEMREAD;
          OP_SW:   state_d = MEMWRITE;
          default: state_d = FETCH;
        endcase
      end
      MEMREAD:  if (MemReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (MemReady) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    AdrSrc    = ADR_PC;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    alu_op    = ALUOP_ADD;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = MemReady;
        pc_update = MemReady;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        illegal = ~is_legal_op(op);
      end
      MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD:  AdrSrc = ADR_ALUOUT;
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = ADR_ALUOUT;
        mem_write = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        alu_op  = ALUOP_FUNC;
      end
      EXECI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNC;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Gating with reset keeps every write strobe low for the whole time reset is held
  assign PCWrite      = reset & ((branch & Zero) | pc_update);
  assign IRWrite      = reset & ir_write;
  assign MemWrite     = reset & mem_write;
  assign RegWrite     = reset & reg_write;
  assign IllegalInstr = reset & illegal;
  assign ImmSrc       = imm_src_of(op);

  aludec u_aludec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

`ifdef RV_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, inst_ret_q;
  logic        retire;

  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                  ((state_q == MEMWRITE) && MemReady);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= 32'd0;
      inst_ret_q  <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire) inst_ret_q <= inst_ret_q + 32'd1;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstRet  = inst_ret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  typedef enum {C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL, C_ILL} cls_t;
  typedef enum {PH_FETCH, PH_DECODE, PH_ADR, PH_RD, PH_MWB, PH_WR,
                PH_EXR, PH_EXI, PH_AWB, PH_BEQ, PH_JAL} ph_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero, MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
`ifdef RV_PERF_CNT_EN
  logic [31:0] CycleCnt, InstRet;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cyc = 0;
  logic [31:0] exp_ret = 0;
  cls_t        cur_cls = C_R;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .IllegalInstr(IllegalInstr)
`ifdef RV_PERF_CNT_EN
    , .CycleCnt(CycleCnt), .InstRet(InstRet)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] op_of(input cls_t c);
    logic [6:0] o;
    case (c)
      C_LW:  o = 7'b0000011;
      C_SW:  o = 7'b0100011;
      C_R:   o = 7'b0110011;
      C_I:   o = 7'b0010011;
      C_BEQ: o = 7'b1100011;
      C_JAL: o = 7'b1101111;
      default: begin
        o = 7'b1111111;
        if ($urandom_range(0, 1) == 1) begin
          do o = 7'($urandom);
          while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                 o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111);
        end
      end
    endcase
    return o;
  endfunction

  // R/I-type ALU result selection straight from the ISA meaning of funct3
  function automatic logic [2:0] func_alu(input logic [2:0] f3, input logic is_r, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  task automatic check_phase(input ph_t ph);
    logic       e_pcw, e_mw, e_irw, e_rw, e_ill, e_adr;
    logic [1:0] e_res, e_sa, e_sb, e_imm;
    logic [2:0] e_alu;
    bit         c_adr, c_res, c_sa, c_sb, c_alu;
    e_pcw = 0; e_mw = 0; e_irw = 0; e_rw = 0; e_ill = 0; e_adr = 0;
    e_res = 0; e_sa = 0; e_sb = 0; e_alu = 0;
    c_adr = 0; c_res = 0; c_sa = 0; c_sb = 0; c_alu = 0;
    @(negedge clk);
    case (ph)
      PH_FETCH:  begin c_adr = 1; c_sa = 1; c_sb = 1; e_sb = 2; c_alu = 1; c_res = 1; e_res = 2;
                       e_irw = MemReady; e_pcw = MemReady; end
      PH_DECODE: begin c_sa = 1; e_sa = 1; c_sb = 1; e_sb = 1; c_alu = 1; e_ill = (cur_cls == C_ILL); end
      PH_ADR:    begin c_sa = 1; e_sa = 2; c_sb = 1; e_sb = 1; c_alu = 1; end
      PH_RD:     begin c_adr = 1; e_adr = 1; end
      PH_MWB:    begin c_res = 1; e_res = 1; e_rw = 1; end
      PH_WR:     begin c_adr = 1; e_adr = 1; e_mw = 1; end
      PH_EXR:    begin c_sa = 1; e_sa = 2; c_sb = 1; e_sb = 0; c_alu = 1; e_alu = func_alu(funct3, 1, funct7b5); end
      PH_EXI:    begin c_sa = 1; e_sa = 2; c_sb = 1; e_sb = 1; c_alu = 1; e_alu = func_alu(funct3, 0, funct7b5); end
      PH_AWB:    begin c_res = 1; e_res = 0; e_rw = 1; end
      PH_BEQ:    begin c_sa = 1; e_sa = 2; c_sb = 1; e_sb = 0; c_alu = 1; e_alu = 3'd1; c_res = 1; e_pcw = Zero; end
      PH_JAL:    begin c_sa = 1; e_sa = 1; c_sb = 1; e_sb = 2; c_alu = 1; c_res = 1; e_pcw = 1; end
      default: ;
    endcase
    if (!reset) begin e_pcw = 0; e_mw = 0; e_irw = 0; e_rw = 0; e_ill = 0; end
    case (cur_cls)
      C_SW:    e_imm = 2'b01;
      C_BEQ:   e_imm = 2'b10;
      C_JAL:   e_imm = 2'b11;
      default: e_imm = 2'b00;
    endcase
    check({ph.name(), ".PCWrite"}, PCWrite, e_pcw);
    check({ph.name(), ".MemWrite"}, MemWrite, e_mw);
    check({ph.name(), ".IRWrite"}, IRWrite, e_irw);
    check({ph.name(), ".RegWrite"}, RegWrite, e_rw);
    check({ph.name(), ".Illegal"}, IllegalInstr, e_ill);
    check({ph.name(), ".ImmSrc"}, ImmSrc, e_imm);
    if (c_adr) check({ph.name(), ".AdrSrc"}, AdrSrc, e_adr);
    if (c_res) check({ph.name(), ".ResultSrc"}, ResultSrc, e_res);
    if (c_sa)  check({ph.name(), ".ALUSrcA"}, ALUSrcA, e_sa);
    if (c_sb)  check({ph.name(), ".ALUSrcB"}, ALUSrcB, e_sb);
    if (c_alu) check({ph.name(), ".ALUControl"}, ALUControl, e_alu);
`ifdef RV_PERF_CNT_EN
    check("CycleCnt", CycleCnt, exp_cyc);
    check("InstRet", InstRet, exp_ret);
`endif
  endtask

  task automatic run_phase(input ph_t ph, input logic mr);
    bit retire;
    MemReady = mr;
    check_phase(ph);
    retire = (ph == PH_MWB) || (ph == PH_AWB) || (ph == PH_BEQ) || (ph == PH_WR && mr);
    @(posedge clk);
    #1;
    if (reset) begin
      exp_cyc = exp_cyc + 1;
      if (retire) exp_ret = exp_ret + 1;
    end
  endtask

  task automatic run_instr(input cls_t c, input logic [2:0] f3, input logic f7,
                           input logic z, input int fwait, input int mwait);
    cur_cls = c; op = op_of(c); funct3 = f3; funct7b5 = f7; Zero = z;
    for (int w = 0; w < fwait; w++) run_phase(PH_FETCH, 1'b0);
    run_phase(PH_FETCH, 1'b1);
    run_phase(PH_DECODE, 1'($urandom));
    case (c)
      C_LW: begin
        run_phase(PH_ADR, 1'($urandom));
        for (int w = 0; w < mwait; w++) run_phase(PH_RD, 1'b0);
        run_phase(PH_RD, 1'b1);
        run_phase(PH_MWB, 1'($urandom));
      end
      C_SW: begin
        run_phase(PH_ADR, 1'($urandom));
        for (int w = 0; w < mwait; w++) run_phase(PH_WR, 1'b0);
        run_phase(PH_WR, 1'b1);
      end
      C_R:   begin run_phase(PH_EXR, 1'($urandom)); run_phase(PH_AWB, 1'($urandom)); end
      C_I:   begin run_phase(PH_EXI, 1'($urandom)); run_phase(PH_AWB, 1'($urandom)); end
      C_BEQ: run_phase(PH_BEQ, 1'($urandom));
      C_JAL: begin run_phase(PH_JAL, 1'($urandom)); run_phase(PH_AWB, 1'($urandom)); end
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b0; MemReady = 1'b1; Zero = 1'b0;
    op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    for (int i = 0; i < 3; i++) run_phase(PH_FETCH, 1'b1);
    reset = 1'b1;

    run_instr(C_R,   3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(C_R,   3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(C_LW,  3'd2, 1'b0, 1'b0, 0, 3);
    run_instr(C_BEQ, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(C_BEQ, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(C_ILL, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(C_I,   3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(C_JAL, 3'd0, 1'b0, 1'b0, 1, 0);

    for (int n = 0; n < 200; n++)
      run_instr(cls_t'($urandom_range(0, 6)), 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));

    // Abort a store mid-MEMWRITE with an asynchronous reset
    cur_cls = C_SW; op = op_of(C_SW);
    run_phase(PH_FETCH, 1'b1);
    run_phase(PH_DECODE, 1'b1);
    run_phase(PH_ADR, 1'b0);
    MemReady = 1'b0;
    check_phase(PH_WR);
    #2 reset = 1'b0;
    exp_cyc = 0; exp_ret = 0;
    #1;
    check("abort.MemWrite", MemWrite, 1'b0);
    check("abort.ALUSrcB", ALUSrcB, 2'b10);
    check("abort.AdrSrc", AdrSrc, 1'b0);
`ifdef RV_PERF_CNT_EN
    check("abort.CycleCnt", CycleCnt, 32'd0);
`endif
    @(posedge clk); #1;
    run_phase(PH_FETCH, 1'b1);
    reset = 1'b1;
    for (int n = 0; n < 20; n++)
      run_instr(cls_t'($urandom_range(0, 6)), 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle RV32I datapath: shared instruction/data memory, IR, OldPC, A/B and ALUOut registers.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Emits the datapath's mux selects, write enables and ALU control.
- Stalls on a single memory-ready handshake.
- Replaces the single-cycle decoder when the core moves to the multicycle datapath.

Parameters:
- none

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low (reset==0 resets)
- op  input  7  Instr[6:0]
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
- MemWrite  output  1  memory store strobe
- IRWrite  output  1  IR and OldPC enable
- RegWrite  output  1  register file write
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  output  2  00=B, 01=ImmExt, 10=const 4
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IllegalInstr  output  1  one-cycle pulse on an undecodable opcode

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Reset: state=FETCH. While reset==0, all enables (PCWrite, MemWrite, IRWrite, RegWrite) and IllegalInstr are 0. Selects take their FETCH values.
- Reset mid-instruction aborts it immediately, with no partial writes after reset asserts.
- Outputs are Moore decodes of state, with these exceptions:
  - ImmSrc decodes combinationally from op: lw/I-type=00, sw=01, beq=10, jal=11, other=00.
  - ALUControl comes from ALUOp (see aludec below).
  - PCWrite = (Branch & Zero) | PCUpdate.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate equal MemReady. Stay in FETCH until MemReady=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - else -> pulse IllegalInstr, go to FETCH with no writes.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until MemReady. Exactly one MemWrite cycle coincides with MemReady=1. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB (writes PC+4 to rd).
- CPI with MemReady tied 1: lw=5, sw=4, R/I=4, beq=3, jal=4.
- aludec mapping:
  - ALUOp 00 -> add
  - ALUOp 01 -> sub
  - ALUOp 10 with funct3 000 -> sub if (op[5] & funct7b5), else add
  - funct3 010 -> slt; 110 -> or; 111 -> and
  - other funct3 -> 000 (add)
- MemReady in any state other than FETCH, MEMREAD or MEMWRITE is ignored.

Optional Feature:
- Macro: RV_PERF_CNT_EN.
- Defined: adds outputs CycleCnt[31:0] and InstRet[31:0], both reset to 0.
  - CycleCnt increments every cycle out of reset.
  - InstRet increments on the last cycle of each legal instruction: MEMWB, MEMWRITE&MemReady, ALUWB, BEQ.
  - Both wrap at 2^32-1 -> 0.
  - Illegal instructions are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum statetype_t
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUControl constants ALU_ADD/SUB/AND/OR/SLT
  - ALUOp and mux-select encodings.
- One sub-module, aludec (ALUOp, funct3, op5, funct7b5 -> ALUControl). The FSM and instruction decode stay in multicycle_controller.

Test Plan:
- reset=0 for 3 cycles with MemReady=1 -> IRWrite, PCWrite, RegWrite, MemWrite all 0. Release reset -> IRWrite=PCWrite=1 in the first cycle, state reaches DECODE.
- add (op 0110011, f3 000, f7b5 0), MemReady=1 -> 4 cycles; EXEC cycle ALUControl=000; RegWrite=1 only in cycle 4 with ResultSrc=00. Same instruction with f7b5=1 -> ALUControl=001.
- lw with MemReady low 3 cycles in MEMREAD -> AdrSrc=1 held 4 cycles, then MEMWB RegWrite=1, ResultSrc=01; total 8 cycles.
- beq with Zero=1 -> PCWrite=1 in BEQ cycle; with Zero=0 -> PCWrite=0. 3 cycles, ImmSrc=10.
- op=1111111 -> IllegalInstr high for exactly the DECODE cycle, no RegWrite/MemWrite, next state FETCH. Under RV_PERF_CNT_EN InstRet is unchanged.
- sw issued, reset asserted during MEMWRITE before MemReady -> MemWrite drops combinationally; after release, fetch restarts. Under RV_PERF_CNT_EN CycleCnt=0 on release.
